// File: rtl/tag_store_if.sv
// tag_store_if: request/response bundle between the cache controller and the tag array
interface tag_store_if #(parameter int INDEX_W = 2, parameter int TAG_W = 6);
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0] tag_in;
  logic rd_en;
  logic wr_en;
  logic inv_en;
  logic flush;
  logic busy;
  logic resp_valid;
  logic hit;
  logic rd_valid;
  logic [TAG_W-1:0] rd_tag;
  modport master(
    output index, tag_in, rd_en, wr_en, inv_en, flush,
    input busy, resp_valid, hit, rd_valid, rd_tag
  );
  modport slave(
    input index, tag_in, rd_en, wr_en, inv_en, flush,
    output busy, resp_valid, hit, rd_valid, rd_tag
  );
endinterface

// File: rtl/tag_store.sv
// tag_store: cache tag array with valid bits, registered tag compare and a sequential flush sweep
module tag_store #(
  parameter int INDEX_W = 2,
  parameter int TAG_W = 6
) (
  input logic clk,
  input logic reset,
  tag_store_if.slave bus
);
  localparam int DEPTH = 2 ** INDEX_W;
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_n;
  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tags [DEPTH];
  logic [INDEX_W-1:0] ptr;
  logic accept, lookup;
  always_comb begin
    state_n = state == IDLE ? (bus.flush ? FLUSH : IDLE) : (&ptr ? IDLE : FLUSH);
    accept = state == IDLE && !bus.flush;
    lookup = accept && bus.rd_en;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  assign bus.busy = state == FLUSH;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
      ptr <= '0;
      bus.resp_valid <= 1'b0;
      bus.hit <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_tag <= '0;
    end else begin
      // Response reads the array before this edge's update lands: read-before-write.
      bus.resp_valid <= lookup;
      bus.rd_valid <= lookup && valid[bus.index];
      bus.hit <= lookup && valid[bus.index] && tags[bus.index] == bus.tag_in;
      if (lookup) bus.rd_tag <= tags[bus.index];
      if (state == FLUSH) begin
        valid[ptr] <= 1'b0;
        ptr <= ptr + 1'b1;
      end else if (accept) begin
        if (bus.inv_en) valid[bus.index] <= 1'b0;
        else if (bus.wr_en) begin
          valid[bus.index] <= 1'b1;
          tags[bus.index] <= bus.tag_in;
        end
      end
    end
  end
endmodule

// File: tb/tb_tag_store.sv
// tb_tag_store: scoreboard bench for tag_store with INDEX_W=2, TAG_W=6
module tb_tag_store;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  tag_store_if #(.INDEX_W(2), .TAG_W(6)) bus();
  tag_store #(.INDEX_W(2), .TAG_W(6)) dut(.clk(clk), .reset(reset), .bus(bus));
  typedef struct packed {logic hit; logic rd_valid; logic [5:0] rd_tag;} resp_t;
  resp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  // Every response the DUT produces is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      resp_t a, e;
      a = '{hit: bus.hit, rd_valid: bus.rd_valid, rd_tag: bus.rd_tag};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp got hit=%b rd_valid=%b rd_tag=%0d, required no response", a.hit, a.rd_valid, a.rd_tag);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          miscompares++;
          $display("FAIL lookup_resp got hit=%b rd_valid=%b rd_tag=%0d, required hit=%b rd_valid=%b rd_tag=%0d",
                   a.hit, a.rd_valid, a.rd_tag, e.hit, e.rd_valid, e.rd_tag);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    bus.index = '0;
    bus.tag_in = '0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.inv_en = 1'b0;
    bus.flush = 1'b0;
  endtask
  task automatic drive(input logic [1:0] i, input logic [5:0] t, input logic r, input logic w, input logic v, input logic f);
    bus.index = i;
    bus.tag_in = t;
    bus.rd_en = r;
    bus.wr_en = w;
    bus.inv_en = v;
    bus.flush = f;
    tick();
    idle_in();
  endtask
  task automatic push(input logic h, input logic v, input logic [5:0] t);
    exp_q.push_back('{hit: h, rd_valid: v, rd_tag: t});
  endtask
  task automatic drain(input string name);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_resp got %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset;
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if ({bus.busy, bus.resp_valid, bus.hit, bus.rd_valid, bus.rd_tag} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b resp_valid=%b hit=%b rd_valid=%b rd_tag=%0d, required all 0",
               bus.busy, bus.resp_valid, bus.hit, bus.rd_valid, bus.rd_tag);
    end
    push(1'b0, 1'b0, 6'd0);
    drive(2'd1, 6'd9, 1, 0, 0, 0);
    drain("reset_miss");
  endtask
  task automatic test_fill;
    drive(2'd1, 6'd9, 0, 1, 0, 0);
    push(1'b1, 1'b1, 6'd9);
    drive(2'd1, 6'd9, 1, 0, 0, 0);
    push(1'b0, 1'b1, 6'd9);
    drive(2'd1, 6'd8, 1, 0, 0, 0);
    push(1'b0, 1'b0, 6'd0);
    drive(2'd2, 6'd9, 1, 0, 0, 0);
    tick();
    vectors++;
    if ({bus.resp_valid, bus.hit, bus.rd_valid} !== 3'b0 || bus.rd_tag !== 6'd0) begin
      miscompares++;
      $display("FAIL idle_hold got resp_valid=%b hit=%b rd_valid=%b rd_tag=%0d, required 0 0 0 tag 0",
               bus.resp_valid, bus.hit, bus.rd_valid, bus.rd_tag);
    end
    drain("fill");
  endtask
  task automatic test_read_during_write;
    drive(2'd3, 6'd5, 0, 1, 0, 0);
    push(1'b0, 1'b1, 6'd5);
    drive(2'd3, 6'd7, 1, 1, 0, 0);
    push(1'b1, 1'b1, 6'd7);
    drive(2'd3, 6'd7, 1, 0, 0, 0);
    drain("rdw");
  endtask
  task automatic test_invalidate;
    drive(2'd1, 6'd9, 0, 0, 1, 0);
    push(1'b0, 1'b0, 6'd9);
    drive(2'd1, 6'd9, 1, 0, 0, 0);
    drive(2'd0, 6'd2, 0, 1, 0, 0);
    drive(2'd0, 6'd4, 0, 1, 1, 0);
    push(1'b0, 1'b0, 6'd2);
    drive(2'd0, 6'd4, 1, 0, 0, 0);
    drain("invalidate");
  endtask
  task automatic test_flush;
    int n = 0;
    for (int i = 0; i < 4; i++) drive(i[1:0], 6'(10 + i), 0, 1, 0, 0);
    bus.flush = 1'b1;
    tick();
    bus.index = 2'd0;
    bus.tag_in = 6'd50;
    bus.rd_en = 1'b1;
    bus.wr_en = 1'b1;
    while (bus.busy === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    idle_in();
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL flush_busy_cycles got %0d, required 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 1'b0, 6'(10 + i));
      drive(i[1:0], 6'(10 + i), 1, 0, 0, 0);
    end
    drain("flush");
  endtask
  task automatic test_reset_mid_flush;
    for (int i = 0; i < 4; i++) drive(i[1:0], 6'(20 + i), 0, 1, 0, 0);
    drive(2'd0, 6'd0, 0, 0, 0, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_flush_busy got %b, required 0", bus.busy);
    end
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 1'b0, 6'd0);
      drive(i[1:0], 6'(20 + i), 1, 0, 0, 0);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_flush_no_sweep got busy=%b, required 0", bus.busy);
    end
    drain("reset_mid_flush");
  endtask
  initial begin
    idle_in();
    reset = 1'b1;
    test_reset();
    test_fill();
    test_read_during_write();
    test_invalidate();
    test_flush();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
